// File: rtl/xbus_fb_ctl.sv
// Xbus framebuffer slave: VRAM window with pan offset, register block, VBL timer and VRAM timeout.
// Optional macro XBUS_FB_POSTED_WRITE_EN posts framebuffer writes through a one-entry buffer.
module xbus_fb_ctl #(
  parameter logic [21:0] FB_BASE  = 22'o17000000,
  parameter int          FB_AW    = 15,
  parameter logic [21:0] REG_BASE = 22'o17377760,
  parameter int          CLK_HZ   = 50000000,
  parameter int          VBL_HZ   = 60,
  parameter int          TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [21:0]      addr,
  input  logic [31:0]      datain,
  input  logic             req,
  input  logic             write,
  output logic [31:0]      dataout,
  output logic             ack,
  output logic             decode,
  output logic             interrupt,
  output logic [FB_AW-1:0] vram_addr,
  output logic [31:0]      vram_data_out,
  input  logic [31:0]      vram_data_in,
  output logic             vram_req,
  input  logic             vram_ready,
  output logic             vram_write,
  input  logic             vram_done
);

  localparam logic [25:0] VBL_DIV = 26'(CLK_HZ / VBL_HZ);
  localparam logic [15:0] TMO     = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state;

  logic             in_fb;
  logic             in_reg;
  logic [FB_AW-1:0] fb_addr;
  logic [15:0]      wait_cnt;
  logic             wait_last;
  logic             fsm_tmo;
  logic             csr_wr;
  logic             wr_strobe;
  logic [25:0]      vbl_cnt;
  logic             vbl_wrap;
  logic [15:0]      frame;
  logic             int_en;
  logic             vbl_flag;
  logic             tmo_err;
  logic [FB_AW-1:0] pan;
  logic [31:0]      reg_rdata;
  logic             post_busy;
  logic             post_tmo;

  assign in_fb   = (addr[21:FB_AW] == FB_BASE[21:FB_AW]);
  assign in_reg  = (addr[21:3] == REG_BASE[21:3]);
  assign decode  = in_fb | in_reg;
  assign fb_addr = addr[FB_AW-1:0] + pan;

  assign wait_last = (wait_cnt + 16'd1 == TMO);
  assign fsm_tmo   = wait_last && (((state == WRITE) && !vram_done) ||
                                   ((state == READ) && !vram_ready));
  assign csr_wr    = (state == IDLE) && req && in_reg && !in_fb && write &&
                     (addr[2:0] == 3'd0);

  always_comb begin
    reg_rdata = '0;
    case (addr[2:0])
      3'd0:    reg_rdata = {26'b0, tmo_err, vbl_flag, int_en, 3'b000};
      3'd1:    reg_rdata = {16'b0, frame};
      3'd2:    reg_rdata[FB_AW-1:0] = pan;
      default: reg_rdata = '0;
    endcase
  end

  // Free-running vertical-blank divider; FRAME counts its wraps.
  assign vbl_wrap = (vbl_cnt == VBL_DIV - 26'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbl_cnt <= '0;
      frame   <= '0;
    end else if (vbl_wrap) begin
      vbl_cnt <= '0;
      frame   <= frame + 16'd1;
    end else begin
      vbl_cnt <= vbl_cnt + 26'd1;
    end
  end

`ifdef XBUS_FB_POSTED_WRITE_EN
  logic [FB_AW-1:0] post_addr;
  logic [31:0]      post_data;
  logic [15:0]      post_cnt;
  logic             post_take;

  assign post_take = (state == IDLE) && req && in_fb && write && !post_busy;
  assign post_tmo  = post_busy && !vram_done && (post_cnt + 16'd1 == TMO);

  // The buffer owns the VRAM write port from capture until done or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      post_busy <= 1'b0;
      post_addr <= '0;
      post_data <= '0;
      post_cnt  <= '0;
    end else if (post_take) begin
      post_busy <= 1'b1;
      post_addr <= fb_addr;
      post_data <= datain;
      post_cnt  <= '0;
    end else if (post_busy) begin
      if (vram_done || post_tmo)
        post_busy <= 1'b0;
      else
        post_cnt <= post_cnt + 16'd1;
    end
  end

  assign vram_addr     = post_busy ? post_addr : fb_addr;
  assign vram_data_out = post_busy ? post_data : datain;
`else
  assign post_busy     = 1'b0;
  assign post_tmo      = 1'b0;
  assign vram_addr     = fb_addr;
  assign vram_data_out = datain;
`endif

  assign vram_write = wr_strobe | post_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dataout   <= '0;
      ack       <= 1'b0;
      vram_req  <= 1'b0;
      wr_strobe <= 1'b0;
      int_en    <= 1'b0;
      vbl_flag  <= 1'b0;
      tmo_err   <= 1'b0;
      pan       <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= int_en & vbl_flag;

      // Hardware set events take priority over software write-1-to-clear.
      if (vbl_wrap)
        vbl_flag <= 1'b1;
      else if (csr_wr && datain[4])
        vbl_flag <= 1'b0;

      if (fsm_tmo || post_tmo)
        tmo_err <= 1'b1;
      else if (csr_wr && datain[5])
        tmo_err <= 1'b0;

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (req && in_fb && !post_busy) begin
            if (write) begin
`ifdef XBUS_FB_POSTED_WRITE_EN
              state <= DONE;
              ack   <= 1'b1;
`else
              state     <= WRITE;
              wr_strobe <= 1'b1;
`endif
            end else begin
              state    <= READ;
              vram_req <= 1'b1;
            end
          end else if (req && in_reg) begin
            state <= DONE;
            ack   <= 1'b1;
            if (write) begin
              if (addr[2:0] == 3'd0) int_en <= datain[3];
              if (addr[2:0] == 3'd2) pan <= datain[FB_AW-1:0];
            end else begin
              dataout <= reg_rdata;
            end
          end
        end
        WRITE: begin
          if (vram_done || wait_last) begin
            state     <= DONE;
            wr_strobe <= 1'b0;
            ack       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        READ: begin
          if (vram_ready || wait_last) begin
            state    <= DONE;
            vram_req <= 1'b0;
            ack      <= 1'b1;
            dataout  <= vram_ready ? vram_data_in : 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
